split_range_checker: RTL and testbench
======================================

// Module: split_range_checker
// PURPOSE
//  Parametrised successor to the fixed split_N constraint stubs. It accepts a stream of
//  candidate assignments for NUM_VARS unsigned variables over a valid/ready handshake.
//  Each variable is checked against a run-time programmable [lo,hi] range, and the block
//  emits one verdict x per candidate. Pass/fail counts are kept for solver statistics.
//  It sits between the candidate generator and the BDD solver's result collector.
// PARAMETERS
//  NUM_VARS  40  number of variables per candidate
//  VAR_W     8   width of each variable slot; narrower variables are zero-extended
//  CNT_W     16  width of the pass and fail counters
//  IDX_W     $clog2(NUM_VARS)  derived; width of the variable index
// PORTS
//  clk        in   1                clock; all state updates on the rising edge
//  rst        in   1                reset, asynchronous, active-high
//  mode       in   1                0 = ALL_TRUE (x is always 1), 1 = RANGE check
//  cfg_we     in   1                write one bound entry this cycle
//  cfg_idx    in   IDX_W            variable index for the write
//  cfg_en     in   1                enable the check for this variable
//  cfg_lo     in   VAR_W            inclusive lower bound
//  cfg_hi     in   VAR_W            inclusive upper bound
//  in_valid   in   1                candidate present
//  in_ready   out  1                block can accept a candidate
//  in_vars    in   NUM_VARS*VAR_W   candidate; variable i is in_vars[i*VAR_W +: VAR_W]
//  out_valid  out  1                verdict present
//  out_ready  in   1                downstream accepts the verdict
//  out_x      out  1                1 = candidate satisfies all enabled constraints
//  out_fail_idx out IDX_W           lowest failing variable index; 0 when out_x = 1
//  cnt_clr    in   1                synchronous clear of both counters
//  pass_cnt   out  CNT_W            number of accepted verdicts with x = 1 (saturating)
//  fail_cnt   out  CNT_W            number of accepted verdicts with x = 0 (saturating)
// BEHAVIOUR
//  - Reset values: out_valid=0, out_x=0, out_fail_idx=0, pass_cnt=0, fail_cnt=0, in_ready=1.
//    Bound table resets to en=0, lo=0, hi=all-ones. Any in-flight candidate is discarded.
//  - Pipeline has two stages:
//    - S1 registers the per-variable pass bits: (!en) | (lo<=v && v<=hi), unsigned compare.
//    - S2 registers out_x (AND of all bits) and out_fail_idx (priority encode, lowest index).
//  - Latency: 2 cycles from an in_valid&&in_ready edge to out_valid, when not stalled.
//    Sustained throughput is 1 candidate per cycle.
//  - Handshake:
//    - S2 advances when !out_valid || out_ready. S1 advances when !s1_valid || S2 advances.
//    - in_ready equals the S1-advance term (combinational from out_ready; no skid buffer).
//    - While out_valid && !out_ready, out_x and out_fail_idx hold stable.
//  - mode is sampled at S1 capture. In ALL_TRUE mode every pass bit is forced to 1.
//  - Bound table:
//    - A cfg write takes effect for candidates captured in S1 in the cycle after the write.
//      A capture in the same cycle as the write uses the old bounds.
//    - cfg_idx >= NUM_VARS: the write is ignored.
//    - lo > hi on an enabled variable: that variable always fails.
//    - A disabled variable always passes.
//  - Counters:
//    - Increment on out_valid && out_ready, and saturate at 2^CNT_W-1.
//    - cnt_clr takes priority over a same-cycle increment; the result is 0.
//  - Simultaneous in-accept and out-accept with a full pipeline: no bubble; both stages move.
// STRUCTURE
//  - Shared package split_pkg holds the mode constants (SPLIT_MODE_ALL_TRUE=1'b0,
//    SPLIT_MODE_RANGE=1'b1), the bound-entry struct {en, lo, hi}, and the index-width helper.
//  - Sub-module split_var_cmp: one instance per variable via generate. It is
//    combinational: (v, en, lo, hi, mode) -> pass bit.
//  - The top level holds the bound table, the S1/S2 registers, the priority encoder, the
//    counters and the handshake logic.
// TESTING
//  - Reset, ALL_TRUE, NUM_VARS=40: 10 back-to-back random candidates with out_ready=1
//    -> first out_x=1 two cycles after the first accept, 1/cycle after that;
//    pass_cnt=10, fail_cnt=0.
//  - RANGE mode, var 3 set to en=1 lo=10 hi=20: in var3 = 9, 10, 20, 21
//    -> out_x = 0,1,1,0; fail_idx = 3,0,0,3.
//  - Vars 5 and 2 fail in the same candidate -> out_fail_idx=2.
//    Var 7 programmed lo=30 hi=5 -> that candidate always fails with fail_idx=7.
//  - Hold out_ready=0 for 5 cycles with in_valid=1
//    -> exactly 2 candidates accepted, then in_ready=0; outputs stable; no loss or duplication.
//  - cfg write to var 0 in the same cycle as an accept -> that candidate uses the old bounds,
//    the next one uses the new bounds. cfg_idx=45 leaves the table unchanged.
//  - CNT_W=4: 20 passing verdicts -> pass_cnt holds at 15.
//    cnt_clr together with an accept -> pass_cnt=0.
//    Assert rst with 2 candidates in flight -> out_valid=0 next cycle; counters=0.

Source files
------------

// File: rtl/split_pkg.sv
// -----------------------------------------------------------------------------
// split_pkg
// Shared definitions for the split range checker:
//   - mode encodings for the per-variable pass bit
//   - default slot width and the bound-table entry type {en, lo, hi}
//   - helper that derives an index width from a variable count
// -----------------------------------------------------------------------------
package split_pkg;

    localparam logic SPLIT_MODE_ALL_TRUE = 1'b0;
    localparam logic SPLIT_MODE_RANGE    = 1'b1;

    // Width of one variable slot. The bound entry below is sized by this value,
    // so a checker instantiated with a different VAR_W must keep it in step.
    localparam int SPLIT_VAR_W = 8;

    typedef struct packed {
        logic                   en;
        logic [SPLIT_VAR_W-1:0] lo;
        logic [SPLIT_VAR_W-1:0] hi;
    } split_bound_t;

    // Index width for n variables; never narrower than one bit.
    function automatic int split_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/split_var_cmp.sv
// -----------------------------------------------------------------------------
// split_var_cmp
// Combinational range check for one candidate variable.
// Ports:
//   v_i     variable value (unsigned)
//   en_i    check enable; a disabled variable always passes
//   lo_i    inclusive lower bound
//   hi_i    inclusive upper bound
//   mode_i  SPLIT_MODE_ALL_TRUE forces a pass, SPLIT_MODE_RANGE checks bounds
//   pass_o  1 when the variable satisfies its constraint
// -----------------------------------------------------------------------------
module split_var_cmp
    import split_pkg::*;
#(
    parameter int VAR_W = SPLIT_VAR_W
) (
    input  logic [VAR_W-1:0] v_i,
    input  logic             en_i,
    input  logic [VAR_W-1:0] lo_i,
    input  logic [VAR_W-1:0] hi_i,
    input  logic             mode_i,
    output logic             pass_o
);

    logic in_range;

    // With lo > hi no value satisfies both compares, so an enabled variable
    // with inverted bounds always fails without any special casing.
    assign in_range = (lo_i <= v_i) && (v_i <= hi_i);
    assign pass_o   = (mode_i == SPLIT_MODE_ALL_TRUE) || !en_i || in_range;

endmodule

// File: rtl/split_range_checker.sv
// -----------------------------------------------------------------------------
// split_range_checker
// Checks a stream of NUM_VARS-variable candidates against a programmable
// per-variable [lo,hi] table and emits one verdict per candidate through a
// two-stage valid/ready pipeline, keeping saturating pass/fail statistics.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   mode                     0 = every candidate passes, 1 = range check
//   cfg_we/idx/en/lo/hi      write one bound-table entry (idx >= NUM_VARS ignored)
//   in_valid/in_ready        candidate handshake; in_vars holds the candidate
//   out_valid/out_ready      verdict handshake
//   out_x                    1 = all enabled constraints satisfied
//   out_fail_idx             lowest failing variable index, 0 on a pass
//   cnt_clr                  synchronous clear of both counters
//   pass_cnt, fail_cnt       saturating counts of accepted verdicts
// -----------------------------------------------------------------------------
module split_range_checker
    import split_pkg::*;
#(
    parameter int NUM_VARS = 40,
    parameter int VAR_W    = SPLIT_VAR_W,
    parameter int CNT_W    = 16,
    parameter int IDX_W    = split_idx_w(NUM_VARS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic                      cfg_we,
    input  logic [IDX_W-1:0]          cfg_idx,
    input  logic                      cfg_en,
    input  logic [VAR_W-1:0]          cfg_lo,
    input  logic [VAR_W-1:0]          cfg_hi,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_VARS*VAR_W-1:0] in_vars,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_x,
    output logic [IDX_W-1:0]          out_fail_idx,
    input  logic                      cnt_clr,
    output logic [CNT_W-1:0]          pass_cnt,
    output logic [CNT_W-1:0]          fail_cnt
);

    // ------------------------------------------------------------------ table
    split_bound_t table_q [NUM_VARS];
    split_bound_t table_d [NUM_VARS];

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        table_d = table_q;
        if (cfg_we) begin
            // Indices with no matching entry (>= NUM_VARS) fall through untouched.
            for (int i = 0; i < NUM_VARS; i++) begin
                if (cfg_idx == IDX_W'(i)) begin
                    table_d[i] = '{en: cfg_en, lo: cfg_lo, hi: cfg_hi};
                end
            end
        end
    end

    // NOTE: the bound table is a register array with a real reset value
    // (disabled, full range), not a RAM, so it is reset like any other state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_VARS; i++) begin
                table_q[i] <= '{en: 1'b0, lo: '0, hi: '1};
            end
        end else begin
            table_q <= table_d;
        end
    end

    // ------------------------------------------------------------ comparators
    logic [NUM_VARS-1:0] pass_vec;

    for (genvar gi = 0; gi < NUM_VARS; gi++) begin : g_cmp
        split_var_cmp #(
            .VAR_W (VAR_W)
        ) u_cmp (
            .v_i    (in_vars[gi*VAR_W +: VAR_W]),
            .en_i   (table_q[gi].en),
            .lo_i   (table_q[gi].lo),
            .hi_i   (table_q[gi].hi),
            .mode_i (mode),
            .pass_o (pass_vec[gi])
        );
    end

    // -------------------------------------------------------------- handshake
    logic s1_valid_q, s1_valid_d;
    logic [NUM_VARS-1:0] s1_pass_q, s1_pass_d;
    logic out_valid_q, out_valid_d;
    logic out_x_q, out_x_d;
    logic [IDX_W-1:0] out_fail_idx_q, out_fail_idx_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic s2_adv, s1_adv;
    logic [IDX_W-1:0] enc_idx;

    // Ready ripples back combinationally from out_ready; with no skid buffer a
    // full pipeline still moves both stages in the same cycle.
    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    // Lowest failing index wins: scanning downward lets the last hit stand.
    always_comb begin
        enc_idx = '0;
        for (int i = NUM_VARS - 1; i >= 0; i--) begin
            if (!s1_pass_q[i]) begin
                enc_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        s1_valid_d     = s1_valid_q;
        s1_pass_d      = s1_pass_q;
        out_valid_d    = out_valid_q;
        out_x_d        = out_x_q;
        out_fail_idx_d = out_fail_idx_q;

        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_pass_d = pass_vec;
            end
        end

        // Verdict registers only change on advance, so they hold under stall.
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_x_d        = &s1_pass_q;
                out_fail_idx_d = enc_idx;
            end
        end
    end

    // --------------------------------------------------------------- counters
    always_comb begin
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        if (cnt_clr) begin
            pass_cnt_d = '0;
            fail_cnt_d = '0;
        end else if (out_valid_q && out_ready) begin
            if (out_x_q) begin
                if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + CNT_W'(1);
            end else begin
                if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q     <= 1'b0;
            s1_pass_q      <= '0;
            out_valid_q    <= 1'b0;
            out_x_q        <= 1'b0;
            out_fail_idx_q <= '0;
            pass_cnt_q     <= '0;
            fail_cnt_q     <= '0;
        end else begin
            s1_valid_q     <= s1_valid_d;
            s1_pass_q      <= s1_pass_d;
            out_valid_q    <= out_valid_d;
            out_x_q        <= out_x_d;
            out_fail_idx_q <= out_fail_idx_d;
            pass_cnt_q     <= pass_cnt_d;
            fail_cnt_q     <= fail_cnt_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_x        = out_x_q;
    assign out_fail_idx = out_fail_idx_q;
    assign pass_cnt     = pass_cnt_q;
    assign fail_cnt     = fail_cnt_q;

endmodule

// File: tb/tb_split_range_checker.sv
// -----------------------------------------------------------------------------
// tb_split_range_checker
// Two checkers share every input: the default one (16-bit counters) and one
// with 4-bit counters for saturation. A negedge monitor keeps a bound-table
// model, pushes the expected verdict for each accepted candidate, pops and
// compares on each accepted verdict, and tracks the expected counters.
// -----------------------------------------------------------------------------
module tb_split_range_checker;
    import split_pkg::*;

    localparam int NV = 40;
    localparam int VW = 8;
    localparam int IW = 6;

    typedef logic [NV*VW-1:0] cand_t;
    typedef struct packed {
        logic          x;
        logic [IW-1:0] idx;
    } verdict_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          mode;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic          cfg_en;
    logic [VW-1:0] cfg_lo, cfg_hi;
    logic          in_valid;
    logic          in_ready, in_ready4;
    cand_t         in_vars;
    logic          out_valid, out_valid4;
    logic          out_ready;
    logic          out_x, out_x4;
    logic [IW-1:0] out_fail_idx, out_fail_idx4;
    logic          cnt_clr;
    logic [15:0]   pass_cnt, fail_cnt;
    logic [3:0]    pass_cnt4, fail_cnt4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    split_range_checker dut (
        .clk(clk), .rst(rst), .mode(mode),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi),
        .in_valid(in_valid), .in_ready(in_ready), .in_vars(in_vars),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_fail_idx(out_fail_idx),
        .cnt_clr(cnt_clr), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
    );

    split_range_checker #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .mode(mode),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi),
        .in_valid(in_valid), .in_ready(in_ready4), .in_vars(in_vars),
        .out_valid(out_valid4), .out_ready(out_ready), .out_x(out_x4), .out_fail_idx(out_fail_idx4),
        .cnt_clr(cnt_clr), .pass_cnt(pass_cnt4), .fail_cnt(fail_cnt4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------ model
    logic          m_en [NV];
    logic [VW-1:0] m_lo [NV];
    logic [VW-1:0] m_hi [NV];
    verdict_t      sb[$];
    int m_pass = 0, m_fail = 0, m_pass4 = 0, m_fail4 = 0;

    function automatic verdict_t model(input cand_t v, input logic md);
        verdict_t r;
        logic [VW-1:0] val;
        r.x   = 1'b1;
        r.idx = '0;
        if (md == SPLIT_MODE_RANGE) begin
            for (int i = 0; i < NV; i++) begin
                val = v[i*VW +: VW];
                if (r.x && m_en[i] && (val < m_lo[i] || val > m_hi[i])) begin
                    r.x   = 1'b0;
                    r.idx = IW'(i);
                end
            end
        end
        return r;
    endfunction

    function automatic int sat_inc(input int c, input int max);
        return (c < max) ? c + 1 : c;
    endfunction

    always @(negedge clk) begin : monitor
        verdict_t e;
        logic     acc;
        if (rst) begin
            sb.delete();
            m_pass = 0; m_fail = 0; m_pass4 = 0; m_fail4 = 0;
            for (int i = 0; i < NV; i++) begin
                m_en[i] = 1'b0; m_lo[i] = '0; m_hi[i] = '1;
            end
        end else begin
            check("pass_cnt", pass_cnt, m_pass);
            check("fail_cnt", fail_cnt, m_fail);
            check("pass_cnt4", pass_cnt4, m_pass4);
            check("fail_cnt4", fail_cnt4, m_fail4);
            acc = 1'b0;
            if (out_valid || out_valid4) begin
                if (sb.size() == 0) begin
                    check("spurious_out_valid", out_valid, 0);
                end else begin
                    e = sb[0];
                    check("out_valid4", out_valid4, 1);
                    check("out_x", out_x, e.x);
                    check("out_fail_idx", out_fail_idx, e.idx);
                    check("out_x4", out_x4, e.x);
                    check("out_fail_idx4", out_fail_idx4, e.idx);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        acc = 1'b1;
                    end
                end
            end
            if (cnt_clr) begin
                m_pass = 0; m_fail = 0; m_pass4 = 0; m_fail4 = 0;
            end else if (acc) begin
                if (e.x) begin
                    m_pass  = sat_inc(m_pass, 65535);
                    m_pass4 = sat_inc(m_pass4, 15);
                end else begin
                    m_fail  = sat_inc(m_fail, 65535);
                    m_fail4 = sat_inc(m_fail4, 15);
                end
            end
            // Verdict uses the table as it stood before any same-cycle write.
            if (in_valid && in_ready) sb.push_back(model(in_vars, mode));
            if (cfg_we && int'(cfg_idx) < NV) begin
                m_en[cfg_idx] = cfg_en; m_lo[cfg_idx] = cfg_lo; m_hi[cfg_idx] = cfg_hi;
            end
        end
    end

    // -------------------------------------------------------------- helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int idx, input logic en, input logic [VW-1:0] lo, input logic [VW-1:0] hi);
        cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_en = en; cfg_lo = lo; cfg_hi = hi;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic send(input cand_t v);
        int budget = 100;
        in_vars  = v;
        in_valid = 1'b1;
        while (!in_ready && budget > 0) begin
            tick();
            budget--;
        end
        if (!in_ready) check("send_timeout", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int budget = 100;
        in_valid = 1'b0;
        while ((sb.size() != 0 || out_valid) && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) check("drain_timeout", sb.size(), 0);
    endtask

    function automatic cand_t setv(input cand_t v, input int i, input logic [VW-1:0] val);
        cand_t r = v;
        r[i*VW +: VW] = val;
        return r;
    endfunction

    function automatic cand_t rand_cand();
        cand_t r;
        for (int i = 0; i < NV; i++) r[i*VW +: VW] = VW'($urandom_range(0, 255));
        return r;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------- stimulus
    initial begin
        cand_t good, cands [5];
        int    acc, p;
        logic  took;

        rst = 1'b1; mode = SPLIT_MODE_ALL_TRUE; cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0;
        cfg_lo = '0; cfg_hi = '0; in_valid = 1'b0; in_vars = '0; out_ready = 1'b1; cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        check("rst_out_valid", out_valid, 0);
        check("rst_out_x", out_x, 0);
        check("rst_fail_idx", out_fail_idx, 0);
        check("rst_pass_cnt", pass_cnt, 0);
        check("rst_fail_cnt", fail_cnt, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_in_ready4", in_ready4, 1);

        // ALL_TRUE: 10 back-to-back random candidates.
        for (int k = 0; k < 10; k++) begin
            in_vars = rand_cand();
            in_valid = 1'b1;
            check("t1_in_ready", in_ready, 1);
            tick();
            if (k == 0) check("t1_latency_early", out_valid, 0);
            else begin
                check("t1_throughput_valid", out_valid, 1);
                check("t1_out_x", out_x, 1);
            end
        end
        in_valid = 1'b0;
        tick();
        check("t1_last_valid", out_valid, 1);
        drain();
        check("t1_pass_cnt", pass_cnt, 10);
        check("t1_fail_cnt", fail_cnt, 0);
        check("t1_pass_cnt4", pass_cnt4, 10);

        // RANGE: var 3 in [10,20].
        mode = SPLIT_MODE_RANGE;
        cfg(3, 1'b1, 8'd10, 8'd20);
        send(setv('0, 3, 8'd9));
        send(setv('0, 3, 8'd10));
        send(setv('0, 3, 8'd20));
        send(setv('0, 3, 8'd21));
        drain();
        check("t2_pass_cnt", pass_cnt, 12);
        check("t2_fail_cnt", fail_cnt, 2);

        // Two failing vars -> lowest index; inverted bounds always fail.
        cfg(2, 1'b1, 8'd100, 8'd200);
        cfg(5, 1'b1, 8'd100, 8'd200);
        send(setv(setv(setv('0, 2, 8'd5), 5, 8'd5), 3, 8'd15));
        good = setv(setv(setv('0, 2, 8'd150), 5, 8'd150), 3, 8'd15);
        send(good);
        cfg(7, 1'b1, 8'd30, 8'd5);
        send(setv(good, 7, 8'd10));
        send(setv(good, 7, 8'd30));
        send(setv(good, 7, 8'd5));
        drain();
        check("t3_pass_cnt", pass_cnt, 13);
        check("t3_fail_cnt", fail_cnt, 6);
        cfg(7, 1'b0, 8'd30, 8'd5);

        // Stall: out_ready low for 5 cycles with in_valid held high.
        cands[0] = setv(good, 3, 8'd0);
        for (int k = 1; k < 5; k++) cands[k] = setv(good, 0, VW'(k));
        out_ready = 1'b0;
        acc = 0;
        p = 0;
        for (int c = 0; c < 5; c++) begin
            in_vars = cands[p];
            in_valid = 1'b1;
            took = in_ready;
            tick();
            if (took) begin
                acc++;
                p++;
            end
            if (c >= 1) begin
                check("t4_stall_valid", out_valid, 1);
                check("t4_stall_x", out_x, 0);
                check("t4_stall_idx", out_fail_idx, 3);
            end
        end
        check("t4_accepted", acc, 2);
        check("t4_in_ready", in_ready, 0);
        check("t4_in_ready4", in_ready4, 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        check("t4_pass_cnt", pass_cnt, 14);
        check("t4_fail_cnt", fail_cnt, 7);

        // cfg write in the same cycle as an accept.
        good = setv(good, 0, 8'd10);
        cfg_we = 1'b1; cfg_idx = '0; cfg_en = 1'b1; cfg_lo = 8'd50; cfg_hi = 8'd60;
        in_vars = good;
        in_valid = 1'b1;
        check("t5_in_ready", in_ready, 1);
        tick();
        cfg_we = 1'b0;
        in_valid = 1'b0;
        send(good);
        drain();
        check("t5_pass_cnt", pass_cnt, 15);
        check("t5_fail_cnt", fail_cnt, 8);
        cfg(45, 1'b1, 8'd255, 8'd0);
        send(setv(good, 0, 8'd55));
        drain();
        check("t5_idx45_pass_cnt", pass_cnt, 16);
        check("t5_idx45_fail_cnt", fail_cnt, 8);

        // Saturation of the 4-bit counters, then clear with an accept.
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("t6_clr_pass", pass_cnt, 0);
        check("t6_clr_fail", fail_cnt, 0);
        mode = SPLIT_MODE_ALL_TRUE;
        for (int k = 0; k < 20; k++) send(rand_cand());
        drain();
        check("t6_pass_cnt", pass_cnt, 20);
        check("t6_pass_cnt4_sat", pass_cnt4, 15);
        check("t6_fail_cnt4", fail_cnt4, 0);
        send(rand_cand());
        tick();
        check("t6_verdict_ready", out_valid, 1);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("t6_clr_accept_pass", pass_cnt, 0);
        check("t6_clr_accept_pass4", pass_cnt4, 0);

        // Reset with two candidates in flight.
        send(rand_cand());
        drain();
        check("t7_pre_pass", pass_cnt, 1);
        out_ready = 1'b0;
        send(rand_cand());
        send(rand_cand());
        check("t7_inflight_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("t7_rst_valid", out_valid, 0);
        check("t7_rst_pass", pass_cnt, 0);
        check("t7_rst_fail", fail_cnt, 0);
        check("t7_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        tick();
        check("t7_no_stale_valid", out_valid, 0);
        send(rand_cand());
        drain();
        check("t7_post_pass", pass_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
